// File: rtl/i4002_ram_scanner.sv
// i4002_ram_scanner
//
// Purpose:
//   Sweeps the second read port of the four i4002 register arrays. Each
//   nibble is compared against a local shadow copy. Every nibble that
//   differs is reported as a change record on a valid/ready stream. The
//   monitor path (front panel, UART dumper) can then track RAM contents
//   without touching i4002 bus timing.
//
// Optional feature (macro I4002_SCAN_INITIAL_DUMP_EN):
//   When the macro is defined, the first sweep after reset, and the first
//   sweep after leaving IDLE, report every location whether or not it
//   changed. That gives a full initial dump of 4*(SCAN_LAST+1) records.
//   When the macro is undefined, only real differences are reported.
//
// Parameters:
//   SCAN_LAST   last address swept (0..31), default 19 = chars 0-15 + status 16-19
//   ADDR_W      addr2 port width, fixed at 5 by the i4002 interface
//
// Ports:
//   sysclk                    system clock
//   reset                     synchronous, active-high reset
//   enable                    scanning permitted; a sweep in progress always completes
//   ramN_addr2   (N = 0..3)   registered read address; all four carry the same value
//   ramN_data2_out            asynchronous read data from register array N
//   rec_valid/rec_ready       change-record handshake
//   rec_data                  {reg[1:0], addr[4:0], data[3:0]}
//   sweep_done                one-cycle pulse after the last address of each sweep
//   busy                      high whenever the FSM is not in IDLE

module i4002_ram_scanner #(
    parameter int SCAN_LAST = 19,
    parameter int ADDR_W    = 5
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] ram0_addr2,
    input  logic [3:0]        ram0_data2_out,
    output logic [ADDR_W-1:0] ram1_addr2,
    input  logic [3:0]        ram1_data2_out,
    output logic [ADDR_W-1:0] ram2_addr2,
    input  logic [3:0]        ram2_data2_out,
    output logic [ADDR_W-1:0] ram3_addr2,
    input  logic [3:0]        ram3_data2_out,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [ADDR_W+5:0] rec_data,
    output logic              sweep_done,
    output logic              busy
);

    localparam int                DEPTH     = SCAN_LAST + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCAN_LAST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET,
        S_CMP,
        S_EMIT,
        S_NEXT
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        sample_reg [4];
    logic [3:0]        mask_reg;
    logic [1:0]        cur_reg;

    logic [3:0]        live_data [4];
    logic [3:0]        shadow_rd [4];
    logic [3:0]        live_mask;
    logic [3:0]        cmp_mask;
    logic              accept;
    logic [3:0]        mask_after_accept;

`ifdef I4002_SCAN_INITIAL_DUMP_EN
    logic              first_sweep_reg;
`endif

    // Returns the lowest set bit of a change mask. Registers are reported
    // in order 0..3. Callers only pass a non-zero mask.
    function automatic logic [1:0] low_bit(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd3;
        if (m[0])      r = 2'd0;
        else if (m[1]) r = 2'd1;
        else if (m[2]) r = 2'd2;
        return r;
    endfunction

    assign live_data[0] = ram0_data2_out;
    assign live_data[1] = ram1_data2_out;
    assign live_data[2] = ram2_data2_out;
    assign live_data[3] = ram3_data2_out;

    // All four arrays are read at the same scan address.
    assign ram0_addr2 = addr_reg;
    assign ram1_addr2 = addr_reg;
    assign ram2_addr2 = addr_reg;
    assign ram3_addr2 = addr_reg;

    // rec_valid is only ever high in EMIT, so this is the record handshake.
    assign accept            = (state_reg == S_EMIT) && rec_valid && rec_ready;
    assign mask_after_accept = mask_reg & ~(4'b0001 << cur_reg);

    // One shadow lane per register array. The shadow must be cleared by
    // reset to mirror the zero-filled i4002 RAM, so it is built from
    // registers rather than a block RAM.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [3:0] shadow_mem [DEPTH];

            always_ff @(posedge sysclk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        shadow_mem[i] <= 4'h0;
                    end
                end else if (accept && (cur_reg == 2'(gi))) begin
                    shadow_mem[addr_reg] <= sample_reg[gi];
                end
            end

            assign shadow_rd[gi] = shadow_mem[addr_reg];
            assign live_mask[gi] = (live_data[gi] != shadow_rd[gi]);
        end
    endgenerate

`ifdef I4002_SCAN_INITIAL_DUMP_EN
    assign cmp_mask = first_sweep_reg ? 4'b1111 : live_mask;
`else
    assign cmp_mask = live_mask;
`endif

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            addr_reg   <= '0;
            mask_reg   <= 4'h0;
            cur_reg    <= 2'd0;
            rec_valid  <= 1'b0;
            rec_data   <= '0;
            sweep_done <= 1'b0;
            busy       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sample_reg[i] <= 4'h0;
            end
`ifdef I4002_SCAN_INITIAL_DUMP_EN
            first_sweep_reg <= 1'b1;
`endif
        end else begin
            sweep_done <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (enable) begin
                        addr_reg  <= '0;
                        busy      <= 1'b1;
                        state_reg <= S_SET;
`ifdef I4002_SCAN_INITIAL_DUMP_EN
                        first_sweep_reg <= 1'b1;
`endif
                    end
                end

                // The address was driven in the previous cycle. This cycle
                // lets the asynchronous RAM read settle before CMP samples it.
                S_SET: begin
                    state_reg <= S_CMP;
                end

                // Freeze all four nibbles. Records report this snapshot, not
                // the live data, so later RAM writes are picked up next sweep.
                S_CMP: begin
                    for (int i = 0; i < 4; i++) begin
                        sample_reg[i] <= live_data[i];
                    end
                    mask_reg <= cmp_mask;
                    if (cmp_mask == 4'h0) begin
                        state_reg <= S_NEXT;
                    end else begin
                        cur_reg   <= low_bit(cmp_mask);
                        rec_data  <= {low_bit(cmp_mask), addr_reg,
                                      live_data[low_bit(cmp_mask)]};
                        rec_valid <= 1'b1;
                        state_reg <= S_EMIT;
                    end
                end

                // rec_valid stays high and rec_data stays unchanged until the
                // record is accepted. The next record, if any, is presented
                // in the cycle right after the handshake.
                S_EMIT: begin
                    if (accept) begin
                        mask_reg <= mask_after_accept;
                        if (mask_after_accept == 4'h0) begin
                            rec_valid <= 1'b0;
                            state_reg <= S_NEXT;
                        end else begin
                            cur_reg  <= low_bit(mask_after_accept);
                            rec_data <= {low_bit(mask_after_accept), addr_reg,
                                         sample_reg[low_bit(mask_after_accept)]};
                        end
                    end
                end

                // enable is only looked at here, at the end of the sweep.
                // Dropping it mid-sweep therefore still completes the sweep.
                S_NEXT: begin
                    if (addr_reg == LAST_ADDR) begin
                        sweep_done <= 1'b1;
                        addr_reg   <= '0;
`ifdef I4002_SCAN_INITIAL_DUMP_EN
                        first_sweep_reg <= 1'b0;
`endif
                        if (enable) begin
                            state_reg <= S_SET;
                        end else begin
                            busy      <= 1'b0;
                            state_reg <= S_IDLE;
                        end
                    end else begin
                        addr_reg  <= addr_reg + 1'b1;
                        state_reg <= S_SET;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                    rec_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i4002_ram_scanner.sv
// Testbench for i4002_ram_scanner.
//
// The RAM is a plain array with asynchronous reads, indexed by the DUT's
// addr2 outputs. The reference model works one sweep at a time. When a
// sweep starts, it walks addresses 0..SCAN_LAST and registers 0..3 and
// queues every nibble that differs from its own shadow copy (or every
// nibble during an initial-dump sweep). RAM is only modified at sweep
// boundaries, so the queue must match the DUT's records exactly, in order.

`timescale 1ns/1ps

module tb_i4002_ram_scanner;

    localparam int LAST = 19;

    logic        sysclk;
    logic        reset;
    logic        enable;
    logic [4:0]  ram0_addr2, ram1_addr2, ram2_addr2, ram3_addr2;
    logic [3:0]  ram0_data2_out, ram1_data2_out, ram2_data2_out, ram3_data2_out;
    logic        rec_valid;
    logic        rec_ready;
    logic [10:0] rec_data;
    logic        sweep_done;
    logic        busy;

    logic [3:0]  ram_m   [4][32];
    logic [3:0]  mshadow [4][32];

    assign ram0_data2_out = ram_m[0][ram0_addr2];
    assign ram1_data2_out = ram_m[1][ram1_addr2];
    assign ram2_data2_out = ram_m[2][ram2_addr2];
    assign ram3_data2_out = ram_m[3][ram3_addr2];

    i4002_ram_scanner #(.SCAN_LAST(LAST), .ADDR_W(5)) dut (
        .sysclk         (sysclk),
        .reset          (reset),
        .enable         (enable),
        .ram0_addr2     (ram0_addr2),
        .ram0_data2_out (ram0_data2_out),
        .ram1_addr2     (ram1_addr2),
        .ram1_data2_out (ram1_data2_out),
        .ram2_addr2     (ram2_addr2),
        .ram2_data2_out (ram2_data2_out),
        .ram3_addr2     (ram3_addr2),
        .ram3_data2_out (ram3_data2_out),
        .rec_valid      (rec_valid),
        .rec_ready      (rec_ready),
        .rec_data       (rec_data),
        .sweep_done     (sweep_done),
        .busy           (busy)
    );

    initial begin
        sysclk = 1'b0;
        forever #25 sysclk = ~sysclk;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc = 0;
    int          sweep_cyc = 0;
    int          valid_cycles = 0;
    int          done_cnt = 0;
    int          exp_total = 0;
    int          got_total = 0;
    int          cur_built = 0;
    int          prev_built = 0;
    int          prev_addr = 0;
    int          ready_mode = 2;      // 0 random, 1 held low, 2 held high
    bit          rand_on = 0;
    bit          period_valid = 0;
    bit          dump_pending = 0;
    bit          stall_prev = 0;
    logic [10:0] stall_data;
    int          stall_addr;
    logic [10:0] exp_q [$];
    logic [10:0] pend_q [$];
    logic [10:0] sweep_log [$];
    logic [10:0] last_log [$];
    int          xfer_cyc [$];
    int          last_xfer [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] log_at(input int i);
        if (i < last_log.size()) return last_log[i];
        return 11'h7FF;
    endfunction

    function automatic int xfer_gap();
        if (last_xfer.size() >= 2) return last_xfer[1] - last_xfer[0];
        return -1;
    endfunction

    // Reference model: the records one sweep should produce, in order.
    task automatic build_sweep();
        int n;
        n = 0;
        for (int a = 0; a <= LAST; a++) begin
            for (int r = 0; r < 4; r++) begin
                if (dump_pending || (ram_m[r][a] != mshadow[r][a])) begin
                    exp_q.push_back({2'(r), 5'(a), ram_m[r][a]});
                    mshadow[r][a] = ram_m[r][a];
                    n++;
                end
            end
        end
        dump_pending = 0;
        exp_total += n;
        prev_built = cur_built;
        cur_built  = n;
    endtask

    task automatic apply_writes();
        logic [10:0] p;
        while (pend_q.size() > 0) begin
            p = pend_q.pop_front();
            ram_m[p[10:9]][p[8:4]] = p[3:0];
        end
        if (rand_on) begin
            int n;
            n = $urandom_range(0, 4);
            for (int k = 0; k < n; k++) begin
                ram_m[$urandom_range(0, 3)][$urandom_range(0, 31)] = 4'($urandom_range(0, 15));
            end
        end
    endtask

    // One clock cycle: drive rec_ready, then check addr stepping, handshake
    // stability, records and sweep boundaries.
    task automatic tick();
        logic [10:0] e;
        @(negedge sysclk);
        cyc++;
        sweep_cyc++;
        case (ready_mode)
            0:       rec_ready = ($urandom_range(0, 3) != 0);
            1:       rec_ready = 1'b0;
            default: rec_ready = 1'b1;
        endcase

        if (int'(ram0_addr2) != prev_addr) begin
            check_val("addr_step", 32'(ram0_addr2), (prev_addr == LAST) ? 0 : prev_addr + 1);
            check_val("addr_lanes", {ram1_addr2, ram2_addr2, ram3_addr2},
                      {ram0_addr2, ram0_addr2, ram0_addr2});
            prev_addr = ram0_addr2;
        end

        if (stall_prev) begin
            check_val("hold_valid", 32'(rec_valid), 1);
            check_val("hold_data", 32'(rec_data), 32'(stall_data));
            check_val("hold_addr", 32'(ram0_addr2), stall_addr);
        end

        if (rec_valid) valid_cycles++;
        if (rec_valid && rec_ready) begin
            got_total++;
            check_val("rec_addr", 32'(rec_data[8:4]), 32'(ram0_addr2));
            if (exp_q.size() == 0) begin
                check_val("rec_extra", got_total, exp_total);
            end else begin
                e = exp_q.pop_front();
                check_val("rec", 32'(rec_data), 32'(e));
            end
            $display("[TB] cyc %0d record reg=%0d addr=%0d data=%0h",
                     cyc, rec_data[10:9], rec_data[8:4], rec_data[3:0]);
            sweep_log.push_back(rec_data);
            xfer_cyc.push_back(cyc);
        end
        stall_prev = rec_valid && !rec_ready;
        stall_data = rec_data;
        stall_addr = ram0_addr2;

        if (sweep_done) begin
            done_cnt++;
            check_val("sweep_drain", exp_q.size(), 0);
            check_val("sweep_busy", 32'(busy), 32'(enable));
            if (period_valid)
                check_val("sweep_len", sweep_cyc, 3 * (LAST + 1) + valid_cycles);
            last_log  = sweep_log;
            last_xfer = xfer_cyc;
            sweep_log.delete();
            xfer_cyc.delete();
            sweep_cyc    = 0;
            valid_cycles = 0;
            period_valid = enable;
            if (enable) begin
                apply_writes();
                build_sweep();
            end
        end
    endtask

    task automatic wait_sweeps(input int n);
        int start;
        int k;
        start = done_cnt;
        k = 0;
        while ((done_cnt - start) < n && k < n * 500) begin
            tick();
            k++;
        end
        if ((done_cnt - start) < n) check_val("sweep_timeout", done_cnt - start, n);
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!rec_valid && k < 500) begin
            tick();
            k++;
        end
        if (!rec_valid) check_val("valid_timeout", 32'(rec_valid), 1);
    endtask

    task automatic wait_addr(input int a);
        int k;
        k = 0;
        while (int'(ram0_addr2) != a && k < 500) begin
            tick();
            k++;
        end
        if (int'(ram0_addr2) != a) check_val("addr_timeout", 32'(ram0_addr2), a);
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        reset     = 1'b1;
        enable    = 1'b0;
        rec_ready = 1'b0;
        @(negedge sysclk);
        cyc++;
        check_val("rst_valid", 32'(rec_valid), 0);
        check_val("rst_addr", {ram0_addr2, ram1_addr2, ram2_addr2, ram3_addr2}, 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_done", 32'(sweep_done), 0);
        check_val("rst_data", 32'(rec_data), 0);
        reset = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int a = 0; a < 32; a++)
                mshadow[r][a] = 4'h0;
        exp_q.delete();
        sweep_log.delete();
        xfer_cyc.delete();
        exp_total    = 0;
        got_total    = 0;
        prev_addr    = 0;
        stall_prev   = 0;
        period_valid = 0;
`ifdef I4002_SCAN_INITIAL_DUMP_EN
        dump_pending = 1;
`endif
    endtask

    task automatic start_scan();
        enable = 1'b1;
`ifdef I4002_SCAN_INITIAL_DUMP_EN
        dump_pending = 1;
`endif
        build_sweep();
        period_valid = 0;
        sweep_cyc    = 0;
        valid_cycles = 0;
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        rec_ready = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int a = 0; a < 32; a++)
                ram_m[r][a] = 4'h0;

        // Reset state, then a few idle cycles.
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        check_val("idle_busy", 32'(busy), 0);
        check_val("idle_addr", 32'(ram0_addr2), 0);

        // Zero RAM, ready high: only dump records (if enabled), then quiet sweeps.
        ready_mode = 2;
        start_scan();
        wait_sweeps(3);
        check_val("quiet_recs", last_log.size(), 0);

        // Single change ram2[5] = A.
        pend_q.push_back({2'd2, 5'd5, 4'hA});
        wait_sweeps(2);
        check_val("one_rec_cnt", last_log.size(), 1);
        check_val("one_rec", 32'(log_at(0)), 32'({2'd2, 5'd5, 4'hA}));
        wait_sweeps(1);
        check_val("one_rec_gone", last_log.size(), 0);

        // Two changes at one address: emitted in register order.
        pend_q.push_back({2'd0, 5'd17, 4'h3});
        pend_q.push_back({2'd3, 5'd17, 4'hC});
        wait_sweeps(2);
        check_val("pair_cnt", last_log.size(), 2);
        check_val("pair_first", 32'(log_at(0)), 32'({2'd0, 5'd17, 4'h3}));
        check_val("pair_second", 32'(log_at(1)), 32'({2'd3, 5'd17, 4'hC}));

        // Same shape with the consumer stalled for 10 cycles.
        pend_q.push_back({2'd0, 5'd17, 4'h5});
        pend_q.push_back({2'd3, 5'd17, 4'h9});
        wait_sweeps(1);
        ready_mode = 1;
        wait_valid();
        for (int i = 0; i < 10; i++) tick();
        check_val("stall_addr", 32'(ram0_addr2), 17);
        check_val("stall_data", 32'(rec_data), 32'({2'd0, 5'd17, 4'h5}));
        ready_mode = 2;
        wait_sweeps(1);
        check_val("stall_cnt", last_log.size(), 2);
        check_val("stall_second", 32'(log_at(1)), 32'({2'd3, 5'd17, 4'h9}));
        check_val("back_to_back", xfer_gap(), 1);

        // Reset while a record is pending, then re-enable.
        pend_q.push_back({2'd1, 5'd3, 4'h7});
        wait_sweeps(1);
        ready_mode = 1;
        wait_valid();
        do_reset();
        ready_mode = 2;
        start_scan();
        wait_sweeps(1);
        check_val("rereport_cnt", last_log.size(), prev_built);

        // Randomised RAM updates with a randomly stalling consumer.
        rand_on    = 1;
        ready_mode = 0;
        wait_sweeps(30);
        rand_on = 0;

        // Drop enable mid-sweep: the sweep finishes, then IDLE.
        pend_q.push_back({2'd2, 5'd12, 4'h1});
        pend_q.push_back({2'd1, 5'd19, 4'hE});
        wait_sweeps(1);
        wait_addr(8);
        enable = 1'b0;
        check_val("drop_busy_mid", 32'(busy), 1);
        wait_sweeps(1);
        for (int i = 0; i < 10; i++) tick();
        check_val("drop_busy", 32'(busy), 0);
        check_val("drop_addr", 32'(ram0_addr2), 0);
        check_val("drop_valid", 32'(rec_valid), 0);
        check_val("drop_total", got_total, exp_total);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
